// File: rtl/zbuf_depth_test.sv
// Z-buffer read-modify-write depth test: reads a 128-bit depth line, compares one lane, writes back and forwards passing fragments.
// Optional one-line cache of the most recently read/written line, enabled by defining ZBUF_LINE_CACHE_EN.
module zbuf_depth_test #(
    parameter int unsigned LANE_BITS = 3,
    parameter logic [15:0] Z_CLEAR   = 16'h7BFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         nd,
    output logic         us_rfd,
    input  logic [31:0]  zbuff_addr,
    input  logic [18:0]  frag_id,
    input  logic [15:0]  frag_z,
    input  logic [15:0]  frag_color,
    output logic [31:0]  mem_addr,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack,
    input  logic         ds_rfd,
    output logic         out_rdy,
    output logic [18:0]  out_frag_id,
    output logic [15:0]  out_color,
    output logic [31:0]  pass_cnt,
    output logic [31:0]  fail_cnt
);

    localparam int unsigned Z_W    = 16;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned ID_W   = 19;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CMP,
        WR,
        OUT
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     f_id;
    logic [Z_W-1:0]      f_z;
    logic [Z_W-1:0]      f_color;
    logic [LINE_W-1:0]   line;

    logic [LANE_BITS-1:0] lane;
    logic [Z_W-1:0]       old_z_c;
    logic [LINE_W-1:0]    new_line_c;
    logic                 pass_c;

    // Z_CLEAR documents the far-plane clear value only; it has no effect on the datapath.
    logic [Z_W-1:0] unused_z_clear;
    assign unused_z_clear = Z_CLEAR;

    assign lane = f_id[LANE_BITS-1:0];

    // Lane extract, lane replace and depth compare for the captured fragment.
    always_comb begin
        old_z_c    = line[Z_W*32'(lane) +: Z_W];
        new_line_c = line;
        new_line_c[Z_W*32'(lane) +: Z_W] = f_z;
        pass_c     = (f_z < old_z_c);
    end

`ifdef ZBUF_LINE_CACHE_EN
    logic              cache_vld;
    logic [ADDR_W-1:0] cache_tag;
    logic              hit_c;

    // The line register doubles as the cached line; the tag names whichever address it holds.
    assign hit_c = cache_vld && (cache_tag == zbuff_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            us_rfd      <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
            out_rdy     <= 1'b0;
            out_frag_id <= '0;
            out_color   <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            f_id        <= '0;
            f_z         <= '0;
            f_color     <= '0;
            line        <= '0;
`ifdef ZBUF_LINE_CACHE_EN
            cache_vld   <= 1'b0;
            cache_tag   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    us_rfd <= 1'b1;
                    if (nd && us_rfd) begin
                        f_id     <= frag_id;
                        f_z      <= frag_z;
                        f_color  <= frag_color;
                        mem_addr <= zbuff_addr;
                        // Negative depths are rejected without touching memory.
                        if (frag_z[Z_W-1]) begin
                            fail_cnt <= fail_cnt + CNT_W'(1);
                        end else begin
                            us_rfd <= 1'b0;
`ifdef ZBUF_LINE_CACHE_EN
                            if (hit_c) begin
                                state <= CMP;
                            end else begin
                                mem_rd <= 1'b1;
                                state  <= RD;
                            end
`else
                            mem_rd <= 1'b1;
                            state  <= RD;
`endif
                        end
                    end
                end

                RD: begin
                    if (mem_ack) begin
                        line   <= mem_rdata;
                        mem_rd <= 1'b0;
                        state  <= CMP;
`ifdef ZBUF_LINE_CACHE_EN
                        cache_vld <= 1'b1;
                        cache_tag <= mem_addr;
`endif
                    end
                end

                CMP: begin
                    if (pass_c) begin
                        line      <= new_line_c;
                        mem_wdata <= new_line_c;
                        mem_wr    <= 1'b1;
                        pass_cnt  <= pass_cnt + CNT_W'(1);
                        state     <= WR;
`ifdef ZBUF_LINE_CACHE_EN
                        cache_vld <= 1'b1;
                        cache_tag <= mem_addr;
`endif
                    end else begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                        us_rfd   <= 1'b1;
                        state    <= IDLE;
                    end
                end

                WR: begin
                    if (mem_ack) begin
                        mem_wr      <= 1'b0;
                        out_rdy     <= 1'b1;
                        out_frag_id <= f_id;
                        out_color   <= f_color;
                        state       <= OUT;
                    end
                end

                OUT: begin
                    if (ds_rfd) begin
                        out_rdy <= 1'b0;
                        us_rfd  <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zbuf_depth_test.sv
// Self-checking bench for zbuf_depth_test: vector table plus stall, reset and cache corner sequences.
module tb_zbuf_depth_test;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         nd = 1'b0;
    logic         us_rfd;
    logic [31:0]  zbuff_addr = '0;
    logic [18:0]  frag_id = '0;
    logic [15:0]  frag_z = '0;
    logic [15:0]  frag_color = '0;
    logic [31:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic         ds_rfd = 1'b1;
    logic         out_rdy;
    logic [18:0]  out_frag_id;
    logic [15:0]  out_color;
    logic [31:0]  pass_cnt;
    logic [31:0]  fail_cnt;

    always #5 clk = ~clk;

    zbuf_depth_test dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nd          (nd),
        .us_rfd      (us_rfd),
        .zbuff_addr  (zbuff_addr),
        .frag_id     (frag_id),
        .frag_z      (frag_z),
        .frag_color  (frag_color),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .ds_rfd      (ds_rfd),
        .out_rdy     (out_rdy),
        .out_frag_id (out_frag_id),
        .out_color   (out_color),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic [18:0] id;
        logic [15:0] z;
        logic [15:0] color;
        logic        pass;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int exp_lat = 5;
    int exp_pass_n = 0;
    int exp_fail_n = 0;
    int n_reads = 0;
    int n_writes = 0;
    logic prev_rdy = 1'b0;

    logic [127:0] mem_lines [16];
    logic [127:0] ref_lines [16];
    logic [31:0]  exp_rd [$];
    logic [159:0] exp_wr [$];
    logic [34:0]  exp_out [$];
`ifdef ZBUF_LINE_CACHE_EN
    bit           cvalid = 1'b0;
    logic [31:0]  ctag = '0;
`endif

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ack one cycle after it sees a request.
    always @(posedge clk) begin
        if (mem_ack && mem_wr) mem_lines[mem_addr[7:4]] = mem_wdata;
        mem_ack <= (mem_rd || mem_wr) && !mem_ack;
        if ((mem_rd || mem_wr) && !mem_ack)
            mem_rdata <= mem_rd ? mem_lines[mem_addr[7:4]] : '0;
    end

    // Memory and output monitors.
    always @(negedge clk) begin
        if (mem_ack) begin
            chk("rd_wr_exclusive", 160'(mem_rd && mem_wr), 160'(0));
            if (mem_rd) begin
                n_reads++;
                if (exp_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read addr=%0h", mem_addr);
                end else begin
                    chk("read_addr", 160'(mem_addr), 160'(exp_rd.pop_front()));
                end
            end
            if (mem_wr) begin
                n_writes++;
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write addr=%0h", mem_addr);
                end else begin
                    logic [159:0] w;
                    w = exp_wr.pop_front();
                    chk("write_addr", 160'(mem_addr), 160'(w[159:128]));
                    chk("write_data", 160'(mem_wdata), 160'(w[127:0]));
                end
            end
        end
        if (out_rdy && !prev_rdy) chk("latency", 160'(cyc - cap_cyc), 160'(exp_lat));
        prev_rdy = out_rdy;
        if (out_rdy && ds_rfd) begin
            if (exp_out.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output id=%0h", out_frag_id);
            end else begin
                logic [34:0] o;
                o = exp_out.pop_front();
                chk("out_frag_id", 160'(out_frag_id), 160'(o[34:16]));
                chk("out_color", 160'(out_color), 160'(o[15:0]));
            end
        end
    end

    task automatic predict(input vec_t v);
        int  idx;
        int  lane;
        bit  hit;
        idx  = int'(v.addr[7:4]);
        lane = int'(v.id[2:0]);
        hit  = 1'b0;
        if (!v.z[15]) begin
`ifdef ZBUF_LINE_CACHE_EN
            hit    = cvalid && (ctag == v.addr);
            cvalid = 1'b1;
            ctag   = v.addr;
`endif
            if (!hit) exp_rd.push_back(v.addr);
        end
        if (v.pass) begin
            ref_lines[idx][lane*16 +: 16] = v.z;
            exp_wr.push_back({v.addr, ref_lines[idx]});
            exp_out.push_back({v.id, v.color});
            exp_pass_n++;
            exp_lat = hit ? 3 : 5;
        end else begin
            exp_fail_n++;
        end
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            if (us_rfd) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("us_rfd_wait", 160'(us_rfd), 160'(1));
        nd = 1'b1; zbuff_addr = v.addr; frag_id = v.id; frag_z = v.z; frag_color = v.color;
        @(posedge clk); #1;
        nd = 1'b0;
        cap_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (us_rfd) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk({tag, "_idle_wait"}, 160'(us_rfd), 160'(1));
        chk({tag, "_pass_cnt"}, 160'(pass_cnt), 160'(exp_pass_n));
        chk({tag, "_fail_cnt"}, 160'(fail_cnt), 160'(exp_fail_n));
    endtask

    vec_t vecs [10];

    initial begin
        vec_t v;
        int   r0;
        int   w0;
        vecs[0] = '{32'h10, 19'd5,       16'h3C00, 16'h1234, 1'b1};
        vecs[1] = '{32'h10, 19'd5,       16'h3C00, 16'h1111, 1'b0};
        vecs[2] = '{32'h30, 19'd7,       16'hBC00, 16'h2222, 1'b0};
        vecs[3] = '{32'h10, 19'd13,      16'h3BFF, 16'h3333, 1'b1};
        vecs[4] = '{32'h40, 19'd8,       16'h7BFF, 16'h4444, 1'b0};
        vecs[5] = '{32'h40, 19'd15,      16'h7BFE, 16'h5555, 1'b1};
        vecs[6] = '{32'h40, 19'd23,      16'h7BFF, 16'h6666, 1'b0};
        vecs[7] = '{32'h50, 19'h7FFFF,   16'h0000, 16'hFFFF, 1'b1};
        vecs[8] = '{32'h10, 19'd6,       16'h4000, 16'h7777, 1'b1};
        vecs[9] = '{32'h10, 19'd4,       16'h8000, 16'h8888, 1'b0};
        for (int i = 0; i < 16; i++) begin
            mem_lines[i] = {8{16'h7BFF}};
            ref_lines[i] = {8{16'h7BFF}};
        end

        #2 rst_n = 1'b0;
        #1;
        chk("rst_us_rfd", 160'(us_rfd), 160'(0));
        chk("rst_mem_rd", 160'(mem_rd), 160'(0));
        chk("rst_mem_wr", 160'(mem_wr), 160'(0));
        chk("rst_out_rdy", 160'(out_rdy), 160'(0));
        chk("rst_mem_addr", 160'(mem_addr), 160'(0));
        chk("rst_mem_wdata", 160'(mem_wdata), 160'(0));
        chk("rst_out_frag_id", 160'(out_frag_id), 160'(0));
        chk("rst_out_color", 160'(out_color), 160'(0));
        chk("rst_pass_cnt", 160'(pass_cnt), 160'(0));
        chk("rst_fail_cnt", 160'(fail_cnt), 160'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i]);
            predict(vecs[i]);
            if (vecs[i].z[15]) chk("neg_us_rfd_next", 160'(us_rfd), 160'(1));
            wait_idle("vec");
        end

        // Downstream stall: output must hold for 10 cycles while upstream stays blocked.
        ds_rfd = 1'b0;
        v = '{32'h60, 19'd1, 16'h1000, 16'hABCD, 1'b1};
        send(v);
        predict(v);
        for (int i = 0; i < 50; i++) begin
            if (out_rdy) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_rdy", 160'(out_rdy), 160'(1));
            chk("stall_id", 160'(out_frag_id), 160'(19'd1));
            chk("stall_color", 160'(out_color), 160'(16'hABCD));
            chk("stall_us_rfd", 160'(us_rfd), 160'(0));
        end
        @(posedge clk); #1;
        ds_rfd = 1'b1;
        @(posedge clk); #1;
        chk("release_out_rdy", 160'(out_rdy), 160'(0));
        chk("release_us_rfd", 160'(us_rfd), 160'(1));
        wait_idle("stall");

        // Reset while a read is outstanding: abandoned, no write, counters cleared.
        v = '{32'h70, 19'd2, 16'h1000, 16'h0BAD, 1'b1};
        send(v);
        chk("rdphase_mem_rd", 160'(mem_rd), 160'(1));
        chk("rdphase_mem_addr", 160'(mem_addr), 160'(32'h70));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_rd", 160'(mem_rd), 160'(0));
        chk("midrst_mem_wr", 160'(mem_wr), 160'(0));
        chk("midrst_us_rfd", 160'(us_rfd), 160'(0));
        chk("midrst_mem_addr", 160'(mem_addr), 160'(0));
        chk("midrst_pass_cnt", 160'(pass_cnt), 160'(0));
        chk("midrst_fail_cnt", 160'(fail_cnt), 160'(0));
        exp_pass_n = 0;
        exp_fail_n = 0;
`ifdef ZBUF_LINE_CACHE_EN
        cvalid = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send(v);
        predict(v);
        wait_idle("post_rst");

        // Two passing fragments to one line: both depths must land in the second write.
        r0 = n_reads;
        w0 = n_writes;
        v = '{32'h20, 19'd0, 16'h2000, 16'h0101, 1'b1};
        send(v); predict(v); wait_idle("line_a");
        v = '{32'h20, 19'd1, 16'h2100, 16'h0202, 1'b1};
        send(v); predict(v); wait_idle("line_b");
`ifdef ZBUF_LINE_CACHE_EN
        chk("pair_reads", 160'(n_reads - r0), 160'(1));
`else
        chk("pair_reads", 160'(n_reads - r0), 160'(2));
`endif
        chk("pair_writes", 160'(n_writes - w0), 160'(2));

        repeat (5) @(negedge clk);
        chk("drain_rd", 160'(exp_rd.size()), 160'(0));
        chk("drain_wr", 160'(exp_wr.size()), 160'(0));
        chk("drain_out", 160'(exp_out.size()), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
